// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA: copies one CPU page into SPRAM while stalling the CPU
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int          XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_write_en,
   input  logic [7:0]  oam_base,
   output logic        cpu_stall,
   output logic [15:0] dma_mem_addr,
   output logic        dma_mem_read_en,
   input  logic [7:0]  dma_mem_rdata,
   output logic [7:0]  oam_wr_addr,
   output logic [7:0]  oam_wr_data,
   output logic        oam_wr_en,
   output logic        dma_done
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t     state;
   logic [7:0] page;
   logic [7:0] base;
   logic [7:0] idx;
   logic       par;
   logic       in_read;
   logic       in_write;

   // Transfer sequencing; par free-runs so alignment depends only on time since reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         page     <= 8'h00;
         base     <= 8'h00;
         idx      <= 8'h00;
         par      <= 1'b0;
         dma_done <= 1'b0;
      end else begin
         par      <= ~par;
         dma_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cpu_write_en && (cpu_addr == DMA_REG_ADDR)) begin
                  page  <= cpu_data_in;
                  base  <= oam_base;
                  idx   <= 8'h00;
                  state <= S_HALT;
               end
            end
            S_HALT:  state <= par ? S_ALIGN : S_READ;
            S_ALIGN: state <= S_READ;
            S_READ:  state <= S_WRITE;
            S_WRITE: begin
               if (idx == LAST_IDX) begin
                  state    <= S_IDLE;
                  dma_done <= 1'b1;
               end else begin
                  idx   <= idx + 8'd1;
                  state <= S_READ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bus outputs are decoded from the registered state so rdata passes straight to SPRAM.
   assign in_read         = (state == S_READ);
   assign in_write        = (state == S_WRITE);
   assign cpu_stall       = (state != S_IDLE);
   assign dma_mem_read_en = in_read;
   assign dma_mem_addr    = in_read ? {page, idx} : 16'h0000;
   assign oam_wr_en       = in_write;
   assign oam_wr_addr     = in_write ? 8'(base + idx) : 8'h00;
   assign oam_wr_data     = in_write ? dma_mem_rdata : 8'h00;

endmodule
